prog_counter: RTL
=================

PROG_COUNTER -- requirements
Module: prog_counter

Interface
REQ-001 Parameter N, default 8, counter width in bits (N >= 2).
REQ-002 Parameter MAX, default 2**N-1, terminal value; count range 0..MAX; 1 <= MAX <= 2**N-1.
REQ-003 Parameter SAT, default 0; 0 = wrap at range ends, 1 = saturate at range ends.
REQ-004 Parameter ONESHOT, default 0; 0 = free-running, 1 = single run IDLE->RUN->DONE.
REQ-005 clock  input  1  rising-edge clock.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 en  input  1  count enable; one step per clock edge while high.
REQ-008 up  input  1  direction; 1 = increment, 0 = decrement; sampled every edge.
REQ-009 load  input  1  synchronous load request.
REQ-010 load_val  input  N  load value; values > MAX are clamped to MAX.
REQ-011 start  input  1  one-shot start; ignored when ONESHOT=0.
REQ-012 clr_ovf  input  1  clears the sticky overflow flag.
REQ-013 cnt  output  N  current count, registered.
REQ-014 tc  output  1  registered one-cycle terminal-count pulse.
REQ-015 ovf  output  1  sticky overflow/underflow flag, registered.
REQ-016 busy  output  1  high while counting is permitted (state RUN).

Function
REQ-017 Step condition: en=1, load=0, state=RUN.
REQ-018 With ONESHOT=0, state SHALL be RUN permanently after reset, so busy=1.
REQ-019 load SHALL take priority over a step: next cnt=min(load_val,MAX); state, tc and ovf unchanged.
REQ-020 Up step, cnt<MAX: cnt+1; down step, cnt>0: cnt-1.
REQ-021 Up step at MAX, wrap mode: cnt->0, ovf set; saturate mode: cnt holds MAX, ovf set.
REQ-022 Down step at 0, wrap mode: cnt->MAX, ovf set; saturate mode: cnt holds 0, ovf set.
REQ-023 tc SHALL be high for exactly the one cycle after any step whose result is MAX (up) or 0 (down), including saturated holds and wraps that land on the terminal value.
REQ-024 ovf set and clr_ovf in the same cycle: set wins; clr_ovf alone clears ovf at the next edge.
REQ-025 ONESHOT=1 FSM: IDLE --start--> RUN; RUN --step reaching terminal--> DONE; DONE --start--> RUN.
REQ-026 On entry to RUN from IDLE or DONE, cnt SHALL be set to 0 if up=1 and to MAX if up=0, unless load is also asserted (load value wins).
REQ-027 In ONESHOT=1, reaching the terminal value SHALL enter DONE and hold cnt; no wrap occurs and ovf is not set by the terminal step.
REQ-028 start while in RUN SHALL be ignored; en=0 in RUN pauses the count without leaving RUN.
REQ-029 Direction change mid-run SHALL take effect at the next step; the terminal value follows the current up.
REQ-030 All outputs SHALL be registered; step latency is 1 clock.

Reset
REQ-031 Reset SHALL force cnt=0, tc=0, ovf=0 immediately, independent of clock.
REQ-032 On reset, state SHALL be IDLE (busy=0) when ONESHOT=1 and RUN (busy=1) when ONESHOT=0.
REQ-033 Reset asserted mid-count SHALL abort the run; counting resumes only after deassertion (and after start when ONESHOT=1).

Verification
REQ-034 N=2, defaults, en=1, up=1 for 5 edges -> cnt 1,2,3,0,1; tc high in the cycle cnt=3; ovf=1 from the wrap edge.
REQ-035 SAT=1, N=2, up=1, 5 steps -> cnt 1,2,3,3,3; ovf=1 after the 4th step; clr_ovf with en=0 -> ovf=0.
REQ-036 MAX=5, load_val=9 with load=1 and en=1 -> cnt=5; down steps -> 4,3,2,1,0 with tc at 0; next step wraps to 5 with ovf=1.
REQ-037 ONESHOT=1, MAX=3: start pulse -> busy=1, cnt 0,1,2,3; DONE entered, busy=0, cnt holds 3, ovf=0; second start restarts at 0.
REQ-038 Reset asserted asynchronously between edges at cnt=2 -> cnt=0, ovf=0, tc=0 before the next edge; ONESHOT=1 returns busy=0.

Source files
------------

// File: rtl/prog_counter.sv
// Programmable up/down counter: wrap or saturate, optional one-shot run with DONE state.
// All outputs registered, one clock per step; no backpressure, a step is taken on every enabled edge.
module prog_counter #(
   parameter int N       = 8,
   parameter int MAX     = 2**N - 1,
   parameter bit SAT     = 1'b0,
   parameter bit ONESHOT = 1'b0
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         en,
   input  logic         up,
   input  logic         load,
   input  logic [N-1:0] load_val,
   input  logic         start,
   input  logic         clr_ovf,
   output logic [N-1:0] cnt,
   output logic         tc,
   output logic         ovf,
   output logic         busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [N-1:0] MAXV      = N'(MAX);
   localparam state_t       RST_STATE = ONESHOT ? IDLE : RUN;

   state_t       state, state_nxt;
   logic [N-1:0] cnt_nxt;
   logic         tc_nxt;
   logic         ovf_nxt;
   logic [N-1:0] load_clamped;
   logic [N-1:0] cnt_inc;
   logic [N-1:0] cnt_dec;
   logic         at_top;
   logic         at_bot;
   logic         restart;
   logic         step;

   assign load_clamped = (load_val > MAXV) ? MAXV : load_val;
   assign cnt_inc      = cnt + 1'b1;
   assign cnt_dec      = cnt - 1'b1;
   assign at_top       = (cnt == MAXV);
   assign at_bot       = (cnt == '0);
   assign restart      = ONESHOT && (state != RUN) && start;
   assign step         = en && !load && (state == RUN);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= RST_STATE;
         cnt   <= '0;
         tc    <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         tc    <= tc_nxt;
         ovf   <= ovf_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      tc_nxt    = 1'b0;
      ovf_nxt   = ovf & ~clr_ovf;

      // A restart seeds the count from the run direction; a concurrent load overrides it below.
      if (restart) begin
         state_nxt = RUN;
         cnt_nxt   = up ? '0 : MAXV;
      end

      if (load) begin
         cnt_nxt = load_clamped;
      end else if (step) begin
         if (up) begin
            if (!at_top) begin
               cnt_nxt = cnt_inc;
               tc_nxt  = (cnt_inc == MAXV);
            end else if (ONESHOT) begin
               tc_nxt = 1'b1;
            end else begin
               ovf_nxt = 1'b1;
               if (SAT) tc_nxt  = 1'b1;
               else     cnt_nxt = '0;
            end
         end else begin
            if (!at_bot) begin
               cnt_nxt = cnt_dec;
               tc_nxt  = (cnt_dec == '0);
            end else if (ONESHOT) begin
               tc_nxt = 1'b1;
            end else begin
               ovf_nxt = 1'b1;
               if (SAT) tc_nxt  = 1'b1;
               else     cnt_nxt = MAXV;
            end
         end
         // One-shot runs stop on the terminal value instead of wrapping.
         if (ONESHOT && tc_nxt) state_nxt = DONE;
      end
   end

   assign busy = (state == RUN);

endmodule
